instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Front-end fetch stage of the miniRISC core.
- Owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake (one fetch outstanding at a time).
- Holds the fetched word in the IF/ID register and presents `id_opcode` / `id_imm16` directly to the decoder and the immediate sign-extension stage.
- Supports branch/jump redirect and downstream stall without losing or duplicating instructions.

## Interface

Parameters:
- `RESET_PC`, `32'h0000_0000`: PC loaded on reset.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, level-held until granted.
- `imem_addr`  out  32  word address of request; equals `pc`, bits [1:0] always 0.
- `imem_gnt`  in  1  memory accepts request this cycle.
- `imem_valid`  in  1  response data valid; exactly one per grant, earliest the cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept; IF/ID must hold.
- `redirect`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0).
- `id_valid`  out  1  IF/ID holds a live instruction.
- `id_instr`  out  32  fetched word.
- `id_pc`  out  32  address of `id_instr`.
- `id_opcode`  out  6  `id_instr[31:26]`, registered.
- `id_imm16`  out  16  `id_instr[15:0]`, registered; feeds the immediate sign-extension stage.

## Operation

- Registers: `pc`, `inflight_pc`, skid buffer (`skid_instr`, `skid_pc`), IF/ID register, FSM state.
- Reset:
  - state REQ, `pc=RESET_PC`.
  - `id_valid=0`; `id_instr`, `id_pc`, `id_opcode`, `id_imm16` all 0.
  - Skid empty, `imem_req=0` while `rst_n` low.
- `blocked = id_valid & stall`.
- Consumption: IF/ID is consumed in any cycle with `id_valid & !stall`. Consumed with no new load -> `id_valid<=0`.
- States:
  - REQ:
    - `imem_req = !blocked & !redirect`.
    - On `imem_gnt`: `inflight_pc<=pc`, `pc<=pc+4`, go to RESP.
  - RESP:
    - Waits for `imem_valid`.
    - If `!blocked`: load IF/ID from `imem_rdata` / `inflight_pc`, then REQ.
    - If `blocked`: load skid, then HELD.
  - HELD:
    - `imem_req=0`.
    - When `!blocked`: move skid into IF/ID, then REQ.
  - DRAIN:
    - Response owed to a flushed fetch.
    - On `imem_valid`: discard, then REQ.
- Redirect (highest priority, any state):
  - `pc<={redirect_pc[31:2],2'b00}`, `id_valid<=0`, skid discarded.
  - REQ: stays REQ. `imem_req` is low that cycle, so no grant can occur.
  - RESP: with `imem_valid` the same cycle, data is discarded and the FSM goes to REQ. Without it, the FSM goes to DRAIN.
  - HELD -> REQ.
  - DRAIN stays DRAIN, with `pc` updated.
- PC arithmetic is modulo 2^32; `32'hFFFF_FFFC + 4` wraps to 0.
- `stall` never drops or duplicates an instruction. Every granted fetch not flushed by redirect appears in IF/ID exactly once, in order.
- Reset mid-operation (any state) returns everything to reset values immediately. Any memory response arriving after reset release and before the first grant is ignored; `imem_valid` is only sampled in RESP/DRAIN.

## Timing

- First request: `imem_req=1` in the first cycle after `rst_n` rises.
- Zero-wait memory (grant cycle N, valid N+1): `id_valid` rises at N+2.
- Sustained throughput: one instruction per 2 cycles.
- Redirect at cycle N with FSM in REQ: a request to the new PC is issued at N+1.
- IF/ID outputs are glitch-free registers. `id_opcode` and `id_imm16` always equal the corresponding fields of `id_instr`.
- `imem_addr` is stable while `imem_req` is high and ungranted.

## Structure

- Shared package `fetch_pkg`:
  - State enum `{REQ, RESP, HELD, DRAIN}`.
  - Field positions `OPC_HI=31`, `OPC_LO=26`, `IMM_HI=15`, `IMM_LO=0`.
  - `INSTR_W=32`, `PC_INC=4`.
- One natural sub-module: `ifid_skid_reg`, a one-entry skid buffer plus the IF/ID register with load/consume/flush.
- PC and FSM stay in the top level.

## Test plan

- Reset release, memory returns `32'h0842_0005` one cycle after grant -> `id_valid` at cycle 2, `id_pc=0`, `id_opcode=6'b000010`, `id_imm16=16'h0005`, next `imem_addr=4`.
- `stall` high 5 cycles while a response arrives -> skid holds it, `imem_req` stays low. On release, instruction at PC 4 appears once, followed by PC 8. No loss or duplicate.
- Redirect to `32'h0000_0103` while in RESP, valid 3 cycles later -> DRAIN discards the response. Next `imem_addr=32'h100`, `id_valid` low until that word returns.
- Redirect in the same cycle as `imem_valid` in RESP -> data dropped, request to the new PC on the next cycle, no DRAIN.
- `rst_n` asserted while in HELD with `id_valid=1` -> all outputs 0 asynchronously, `imem_addr=RESET_PC` after release.
- Redirect to `32'hFFFF_FFFC` -> fetches `FFFF_FFFC`, then wraps to `0000_0000`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the miniRISC fetch stage.
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    RESP  = 2'd1,
    HELD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  function automatic logic [OPC_HI-OPC_LO:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [IMM_HI-IMM_LO:0] imm16_of(input logic [INSTR_W-1:0] w);
    return w[IMM_HI:IMM_LO];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_skid_reg.sv
// One-entry skid buffer in front of the IF/ID pipeline register.
`default_nettype none

module ifid_skid_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               consume,
  input  logic               load_in,
  input  logic               load_skid,
  input  logic               move_skid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [31:0]        in_pc,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [5:0]         id_opcode,
  output logic [15:0]        id_imm16
);

  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;
  logic [INSTR_W-1:0] src_instr;
  logic [31:0]        src_pc;

  assign src_instr = move_skid ? skid_instr : in_instr;
  assign src_pc    = move_skid ? skid_pc    : in_pc;

  // Skid occupancy is implied by the HELD state in the parent, so no flag is kept here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_instr <= '0;
      skid_pc    <= '0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
      id_opcode  <= '0;
      id_imm16   <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else begin
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
      end
      if (load_in || move_skid) begin
        id_valid  <= 1'b1;
        id_instr  <= src_instr;
        id_pc     <= src_pc;
        id_opcode <= opcode_of(src_instr);
        id_imm16  <= imm16_of(src_instr);
      end else if (consume) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// miniRISC fetch stage: PC, single-outstanding imem handshake, redirect and stall.
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [5:0]         id_opcode,
  output logic [15:0]        id_imm16
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, inflight_pc, redirect_aligned;
  logic         blocked, granted, load_in, load_skid, move_skid;

  assign blocked          = id_valid & stall;
  assign redirect_aligned = redirect_pc & ~32'h3;
  assign imem_addr        = pc;
  // Gated by rst_n so the request is low for the whole reset assertion.
  assign imem_req         = rst_n & (state == REQ) & ~blocked & ~redirect;
  assign granted          = imem_req & imem_gnt;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load_in   = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (redirect) begin
      pc_nxt = redirect_aligned;
    end else if (granted) begin
      pc_nxt = pc + 32'(PC_INC);
    end
    case (state)
      REQ: begin
        if (granted) state_nxt = RESP;
      end
      RESP: begin
        if (redirect) begin
          state_nxt = imem_valid ? REQ : DRAIN;
        end else if (imem_valid) begin
          load_in   = ~blocked;
          load_skid = blocked;
          state_nxt = blocked ? HELD : REQ;
        end
      end
      HELD: begin
        if (redirect) begin
          state_nxt = REQ;
        end else if (!blocked) begin
          move_skid = 1'b1;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (imem_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (granted) inflight_pc <= pc;
    end
  end

  ifid_skid_reg u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .consume   (id_valid & ~stall),
    .load_in   (load_in),
    .load_skid (load_skid),
    .move_skid (move_skid),
    .in_instr  (imem_rdata),
    .in_pc     (inflight_pc),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_opcode (id_opcode),
    .id_imm16  (id_imm16)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Directed-vector bench for instr_fetch_unit.
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode;
  logic [15:0] id_imm16;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_opcode   (id_opcode),
    .id_imm16    (id_imm16)
  );

  typedef struct {
    logic        st, g, v, rr;
    logic [31:0] rd, rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_idv;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic g, logic v, logic [31:0] rd, logic rr,
                              logic [31:0] rpc, logic e_req, logic [31:0] e_addr,
                              logic e_idv, logic [31:0] e_pc, logic [31:0] e_instr);
    vec_t t;
    t.st = st; t.g = g; t.v = v; t.rd = rd; t.rr = rr; t.rpc = rpc;
    t.e_req = e_req; t.e_addr = e_addr; t.e_idv = e_idv; t.e_pc = e_pc; t.e_instr = e_instr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr);
    logic [31:0] w;
    w = e_instr;
    check({tag, " id_pc"}, id_pc, e_pc);
    check({tag, " id_instr"}, id_instr, e_instr);
    check({tag, " id_opcode"}, 32'(id_opcode), 32'(w[31:26]));
    check({tag, " id_imm16"}, 32'(id_imm16), 32'(w[15:0]));
  endtask

  task automatic drive(input logic st, input logic g, input logic v, input logic [31:0] rd,
                       input logic rr, input logic [31:0] rpc);
    stall = st; imem_gnt = g; imem_valid = v; imem_rdata = rd;
    redirect = rr; redirect_pc = rpc;
  endtask

  initial begin
    int budget;
    // cycle-by-cycle: inputs for the cycle, outputs observed during that cycle
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'h0,       0,0,0));            // c0 grant pc0
    vecs.push_back(mk(0,0,1,32'h0842_0005,0,0,0,32'h4,      0,0,0));            // c1 response
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'h4,       1,32'h0,32'h0842_0005));
    vecs.push_back(mk(1,0,1,32'h1111_0004,0,0,0,32'h8,      0,0,0));            // c3 stall begins
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,0,0,0,0,0,         0,32'h8,       1,32'h4,32'h1111_0004));
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'h8,       1,32'h4,32'h1111_0004));
    vecs.push_back(mk(0,0,1,32'h2222_0008,0,0,0,32'hC,      0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,           1,32'hC,       1,32'h8,32'h2222_0008));
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'hC,       0,0,0));            // c11 grant pc C
    vecs.push_back(mk(0,0,0,0,1,32'h103,     0,32'h10,      0,0,0));            // c12 redirect in RESP
    vecs.push_back(mk(0,0,0,0,0,0,           0,32'h100,     0,0,0));            // DRAIN
    vecs.push_back(mk(0,0,0,0,0,0,           0,32'h100,     0,0,0));
    vecs.push_back(mk(0,0,1,32'hDEAD_0012,0,0,0,32'h100,    0,0,0));            // stale response
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'h100,     0,0,0));
    vecs.push_back(mk(0,0,1,32'h3333_0100,0,0,0,32'h104,    0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'h104,     1,32'h100,32'h3333_0100));
    vecs.push_back(mk(0,0,1,32'hBAD0_0104,1,32'hFFFF_FFFC,0,32'h108, 0,0,0));   // redirect + valid
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'hFFFF_FFFC,0,0,0));
    vecs.push_back(mk(0,0,1,32'h4444_FFFC,0,0,0,32'h0,      0,0,0));            // pc wrapped
    vecs.push_back(mk(0,1,0,0,0,0,           1,32'h0,       1,32'hFFFF_FFFC,32'h4444_FFFC));
    vecs.push_back(mk(0,0,1,32'h5555_0000,0,0,0,32'h4,      0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h203,     0,32'h4,       1,32'h0,32'h5555_0000)); // redirect in REQ
    vecs.push_back(mk(0,0,0,0,0,0,           1,32'h200,     0,0,0));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst imem_req", 32'(imem_req), 0);
    check("rst id_valid", 32'(id_valid), 0);
    check_id("rst", 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].g, vecs[i].v, vecs[i].rd, vecs[i].rr, vecs[i].rpc);
      #1;
      check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d id_valid", i), 32'(id_valid), 32'(vecs[i].e_idv));
      if (vecs[i].e_idv) check_id($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr);
      @(negedge clk);
    end

    // fetch at 0x200, then stall with a live instruction and reset asynchronously
    drive(0,1,0,0,0,0);
    @(negedge clk);
    drive(0,0,1,32'h6666_0200,0,0);
    @(negedge clk);
    drive(1,0,0,0,0,0);
    #1;
    check("pre-rst id_valid", 32'(id_valid), 1);
    check("pre-rst imem_req", 32'(imem_req), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst id_valid", 32'(id_valid), 0);
    check_id("async rst", 0, 0);
    check("async rst imem_req", 32'(imem_req), 0);
    check("async rst imem_addr", imem_addr, 32'h0);

    // stray response around reset release must be ignored
    drive(0,0,1,32'hBEEF_0001,0,0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst imem_req", 32'(imem_req), 1);
    check("post-rst imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    drive(0,1,0,0,0,0);
    #1;
    check("stray ignored id_valid", 32'(id_valid), 0);
    @(negedge clk);
    drive(0,0,1,32'h0842_0005,0,0);
    @(negedge clk);
    drive(0,0,0,0,0,0);

    budget = 0;
    while (!id_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #1;
    check("post-rst fetch id_valid", 32'(id_valid), 1);
    check_id("post-rst fetch", 32'h0, 32'h0842_0005);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
